// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-addressed load/store to word memory port with RMW and load extend
// Optional MISALIGN_TRAP_EN: misaligned/reserved-size requests answer with resp_err instead of accessing memory.
module mem_access_unit #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_dataIn,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [31:0]       mem_dataOut
);

    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CW-1:0] LAST_RD = CW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} stateType;

    stateType          state, nextState;
    logic              writeReg, signedReg, errReg, trapReq;
    logic [1:0]        sizeReg;
    logic [ADDR_W+1:0] addrReg, alignedAddr;
    logic [31:0]       wdataReg, rdWord, mergedWord, loadData;
    logic [CW-1:0]     latCnt;
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic              unusedAddrBits;

    assign unusedAddrBits = ^req_addr[31:ADDR_W+2];

    // Misaligned requests are silently aligned down unless trapping is enabled
    always_comb begin
        alignedAddr = req_addr[ADDR_W+1:0];
        case (req_size)
            2'b00:   ;
            2'b01:   alignedAddr[0] = 1'b0;
            default: alignedAddr[1:0] = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign trapReq = (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                     (req_size == 2'b11);
`else
    assign trapReq = 1'b0;
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (trapReq)
                        nextState = RESP;
                    else if (req_write && req_size[1])
                        nextState = WRITE;
                    else
                        nextState = READ;
                end
            end
            READ: begin
                if (latCnt == LAST_RD)
                    nextState = writeReg ? WRITE : RESP;
            end
            WRITE:   nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            writeReg  <= 1'b0;
            signedReg <= 1'b0;
            errReg    <= 1'b0;
            sizeReg   <= 2'b00;
            addrReg   <= '0;
            wdataReg  <= 32'd0;
            rdWord    <= 32'd0;
            latCnt    <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && req_valid) begin
                writeReg  <= req_write;
                signedReg <= req_signed;
                sizeReg   <= req_size;
                addrReg   <= alignedAddr;
                wdataReg  <= req_wdata;
                errReg    <= trapReq;
                latCnt    <= '0;
            end
            if (state == READ) begin
                latCnt <= latCnt + CW'(1);
                if (latCnt == LAST_RD)
                    rdWord <= mem_dataOut;
            end
        end
    end

    always_comb begin
        mergedWord = rdWord;
        case (sizeReg)
            2'b00:   mergedWord[{addrReg[1:0], 3'b000} +: 8] = wdataReg[7:0];
            2'b01:   mergedWord[{addrReg[1], 4'b0000} +: 16] = wdataReg[15:0];
            default: mergedWord = wdataReg;
        endcase
    end

    always_comb begin
        case (addrReg[1:0])
            2'b00:   laneByte = rdWord[7:0];
            2'b01:   laneByte = rdWord[15:8];
            2'b10:   laneByte = rdWord[23:16];
            default: laneByte = rdWord[31:24];
        endcase
        laneHalf = addrReg[1] ? rdWord[31:16] : rdWord[15:0];
        case (sizeReg)
            2'b00:   loadData = {{24{signedReg & laneByte[7]}}, laneByte};
            2'b01:   loadData = {{16{signedReg & laneHalf[15]}}, laneHalf};
            default: loadData = rdWord;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once
    assign req_ready    = (state == IDLE);
    assign mem_memRead  = (state == READ);
    assign mem_memWrite = (state == WRITE);
    assign mem_address  = addrReg[ADDR_W+1:2];
    assign mem_dataIn   = (state == WRITE) ? mergedWord : 32'd0;
    assign resp_valid   = (state == RESP);
    assign resp_err     = (state == RESP) && errReg;
    assign resp_rdata   = (state == RESP && !writeReg && !errReg) ? loadData : 32'd0;

endmodule
